// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates CPU and host accesses onto one data-memory SRAM port.
//   CPU-first policy with a bounded host wait (HOST_WAIT_MAX refusals, then one forced host slot).
//   Ports: clk/rst (sync, active-high); enable; cpu_req/wen/addr/wdata -> cpu_stall, cpu_rdata/rvalid;
//   host_req/wen/addr/wdata -> host_gnt, host_rdata/rvalid; mem_addr/wen/ren/wdata -> SRAM, mem_rdata <- SRAM.
//   Optional macro DMEM_ARB_STATS_EN adds saturating stall_cnt and conflict_cnt outputs.
module dmem_arbiter #(
   parameter int ADDR_W        = 10,
   parameter int DATA_W        = 32,
   parameter int HOST_WAIT_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              cpu_req,
   input  logic              cpu_wen,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_stall,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   input  logic              host_req,
   input  logic              host_wen,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_rvalid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic              mem_ren,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       conflict_cnt
`endif
);
   typedef enum logic {CPU_PRIO, HOST_FORCE} state_t;
   state_t            state, state_nx;
   logic [7:0]        hwait, hwait_nx;
   logic              cpu_act, cpu_gnt, host_refused, wait_full;
   logic              rd_cpu, rd_host;
   logic [DATA_W-1:0] cpu_rdata_q, host_rdata_q;
   always_comb begin
      cpu_act      = cpu_req & enable;
      cpu_gnt      = cpu_act & (state == CPU_PRIO);
      host_gnt     = host_req & ~cpu_gnt;
      cpu_stall    = cpu_act & ~cpu_gnt;
      mem_addr     = cpu_gnt ? cpu_addr  : host_gnt ? host_addr  : '0;
      mem_wdata    = cpu_gnt ? cpu_wdata : host_gnt ? host_wdata : '0;
      mem_wen      = cpu_gnt ? cpu_wen   : host_gnt & host_wen;
      mem_ren      = cpu_gnt ? ~cpu_wen  : host_gnt & ~host_wen;
      // a host refusal can only happen in CPU_PRIO, where the CPU took the slot
      host_refused = host_req & cpu_gnt;
      wait_full    = hwait == 8'(HOST_WAIT_MAX - 1);
      state_nx     = (host_refused & wait_full) ? HOST_FORCE : CPU_PRIO;
      hwait_nx     = (host_refused & ~wait_full) ? hwait + 8'd1 : 8'd0;
   end
   // rst also masks the pulse combinationally so a reset in the data cycle drops it
   assign cpu_rvalid  = rd_cpu & ~rst;
   assign host_rvalid = rd_host & ~rst;
   assign cpu_rdata   = cpu_rvalid  ? mem_rdata : cpu_rdata_q;
   assign host_rdata  = host_rvalid ? mem_rdata : host_rdata_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= CPU_PRIO;
         hwait        <= '0;
         rd_cpu       <= 1'b0;
         rd_host      <= 1'b0;
         cpu_rdata_q  <= '0;
         host_rdata_q <= '0;
      end else begin
         state        <= state_nx;
         hwait        <= hwait_nx;
         rd_cpu       <= cpu_gnt & ~cpu_wen;
         rd_host      <= host_gnt & ~host_wen;
         cpu_rdata_q  <= cpu_rdata;
         host_rdata_q <= host_rdata;
      end
   end
`ifdef DMEM_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt    <= '0;
         conflict_cnt <= '0;
      end else begin
         if (cpu_stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 32'd1;
         if (cpu_act && host_req && !(&conflict_cnt)) conflict_cnt <= conflict_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed plus randomized check of dmem_arbiter against a behavioural model.
module tb_dmem_arbiter;
   localparam int AW = 10, DW = 32, WMAX = 4;
   logic clk = 1'b0;
   logic rst, enable, cpu_req, cpu_wen, host_req, host_wen;
   logic [AW-1:0] cpu_addr, host_addr;
   logic [DW-1:0] cpu_wdata, host_wdata;
   logic cpu_stall, cpu_rvalid, host_gnt, host_rvalid, mem_wen, mem_ren;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] cpu_rdata, host_rdata, mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic cpu_stall_1, cpu_rvalid_1, host_gnt_1, host_rvalid_1, mem_wen_1, mem_ren_1;
   logic [AW-1:0] mem_addr_1;
   logic [DW-1:0] cpu_rdata_1, host_rdata_1, mem_wdata_1;
   logic [DW-1:0] mem_rdata_1 = '0;
`ifdef DMEM_ARB_STATS_EN
   logic [31:0] stall_cnt, conflict_cnt, stall_cnt_1, conflict_cnt_1;
`endif
   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HOST_WAIT_MAX(WMAX)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
      .host_req(host_req), .host_wen(host_wen), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
      .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
      , .stall_cnt(stall_cnt), .conflict_cnt(conflict_cnt)
`endif
   );
   // second instance: HOST_WAIT_MAX = 1 alternation, shares inputs
   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HOST_WAIT_MAX(1)) dut1 (
      .clk(clk), .rst(rst), .enable(enable),
      .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_stall(cpu_stall_1), .cpu_rdata(cpu_rdata_1), .cpu_rvalid(cpu_rvalid_1),
      .host_req(host_req), .host_wen(host_wen), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt_1), .host_rdata(host_rdata_1), .host_rvalid(host_rvalid_1),
      .mem_addr(mem_addr_1), .mem_wen(mem_wen_1), .mem_ren(mem_ren_1), .mem_wdata(mem_wdata_1),
      .mem_rdata(mem_rdata_1)
`ifdef DMEM_ARB_STATS_EN
      , .stall_cnt(stall_cnt_1), .conflict_cnt(conflict_cnt_1)
`endif
   );
   always #5 clk = ~clk;
   logic [DW-1:0] sram [1024];
   always @(posedge clk) begin
      if (mem_wen) sram[mem_addr] <= mem_wdata;
      if (mem_ren) mem_rdata <= sram[mem_addr];
   end
   logic [DW-1:0] ref_mem [1024];
   int passed = 0, total = 0;
   int refusals = 0;
   bit force_now = 0, pend_c = 0, pend_h = 0, last_stall = 0;
   logic [DW-1:0] pend_data = '0, m_cpu_rd = '0, m_host_rd = '0;
   longint m_stall = 0, m_conf = 0;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask
   task automatic set_in(input bit en, input bit cr, input bit cw, input int ca, input logic [DW-1:0] cd,
                         input bit hr, input bit hw, input int ha, input logic [DW-1:0] hd);
      enable = en; cpu_req = cr; cpu_wen = cw; cpu_addr = AW'(ca); cpu_wdata = cd;
      host_req = hr; host_wen = hw; host_addr = AW'(ha); host_wdata = hd;
   endtask
   // one clock: predict from the model, check at negedge, advance the model at posedge
   task automatic cycle(input bit do_chk);
      bit ca, cw, hw, crv, hrv;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed, nd;
      ca = cpu_req && enable;
      cw = ca && !force_now;
      hw = host_req && !cw;
      ea = cw ? cpu_addr : hw ? host_addr : '0;
      ed = cw ? cpu_wdata : hw ? host_wdata : '0;
      crv = pend_c && !rst;
      hrv = pend_h && !rst;
      last_stall = ca && !cw;
      @(negedge clk);
      if (do_chk) begin
         chk("host_gnt", host_gnt, hw);
         chk("cpu_stall", cpu_stall, last_stall);
         chk("mem_addr", mem_addr, ea);
         chk("mem_wdata", mem_wdata, ed);
         chk("mem_wen", mem_wen, (cw && cpu_wen) || (hw && host_wen));
         chk("mem_ren", mem_ren, (cw && !cpu_wen) || (hw && !host_wen));
         chk("cpu_rvalid", cpu_rvalid, crv);
         chk("host_rvalid", host_rvalid, hrv);
         chk("cpu_rdata", cpu_rdata, crv ? pend_data : m_cpu_rd);
         chk("host_rdata", host_rdata, hrv ? pend_data : m_host_rd);
`ifdef DMEM_ARB_STATS_EN
         chk("stall_cnt", stall_cnt, m_stall);
         chk("conflict_cnt", conflict_cnt, m_conf);
`endif
      end
      @(posedge clk);
      nd = cw ? ref_mem[cpu_addr] : ref_mem[host_addr];
      if (cw && cpu_wen) ref_mem[cpu_addr] = cpu_wdata;
      else if (hw && host_wen) ref_mem[host_addr] = host_wdata;
      if (rst) begin
         m_cpu_rd = '0; m_host_rd = '0; pend_c = 0; pend_h = 0;
         force_now = 0; refusals = 0; m_stall = 0; m_conf = 0;
      end else begin
         if (pend_c) m_cpu_rd = pend_data;
         if (pend_h) m_host_rd = pend_data;
         pend_c = cw && !cpu_wen;
         pend_h = hw && !host_wen;
         pend_data = nd;
         if (last_stall) m_stall++;
         if (ca && host_req) m_conf++;
         if (force_now) begin
            force_now = 0; refusals = 0;
         end else if (host_req && !hw) begin
            refusals++;
            if (refusals == WMAX) begin force_now = 1; refusals = 0; end
         end else refusals = 0;
      end
      #1;
   endtask
   initial begin
      for (int i = 0; i < 1024; i++) begin
         sram[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
         ref_mem[i] = sram[i];
      end
      sram[5] = 32'hDEAD_BEEF;
      ref_mem[5] = 32'hDEAD_BEEF;
      // reset with random reads held
      rst = 1;
      set_in($urandom_range(0, 1), $urandom_range(0, 1), 0, $urandom_range(0, 15), $urandom,
             $urandom_range(0, 1), 0, $urandom_range(0, 15), $urandom);
      cycle(0);
      cycle(0);
      cycle(1);
      chk("reset_cpu_rvalid", cpu_rvalid, 0);
      chk("reset_cpu_rdata", cpu_rdata, 0);
      chk("reset_host_rdata", host_rdata, 0);
      // first CPU read after reset
      rst = 0;
      set_in(1, 1, 0, 5, 0, 0, 0, 0, 0);
      cycle(1);
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("addr5_rvalid", cpu_rvalid, 1);
      chk("addr5_rdata", cpu_rdata, 32'hDEAD_BEEF);
      cycle(1);
      // full contention after a fresh reset
      rst = 1;
      cycle(1);
      rst = 0;
      set_in(1, 1, 0, 1, 0, 1, 0, 2, 0);
      for (int k = 0; k < 10; k++) begin
         chk("contend_host_gnt", host_gnt, k % 5 == 4);
         chk("contend_cpu_stall", cpu_stall, k % 5 == 4);
         chk("max1_host_gnt", host_gnt_1, k % 2 == 1);
         cycle(1);
      end
`ifdef DMEM_ARB_STATS_EN
      chk("stats_conflict10", conflict_cnt, 10);
      chk("stats_stall2", stall_cnt, 2);
`endif
      // enable low: host always wins
      set_in(0, 1, 0, 1, 0, 1, 0, 9, 0);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("dis_host_gnt", host_gnt, 1);
         chk("dis_cpu_stall", cpu_stall, 0);
         chk("dis_mem_addr", mem_addr, 9);
         cycle(1);
      end
      // host write in forced slot, then CPU reads it
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(1);
      set_in(1, 1, 0, 3, 0, 1, 1, 3, 32'h1234_5678);
      for (int k = 0; k < 5; k++) begin
         if (k == 4) begin
            chk("forced_host_gnt", host_gnt, 1);
            chk("forced_mem_wen", mem_wen, 1);
         end
         cycle(1);
      end
      set_in(1, 1, 0, 3, 0, 0, 0, 0, 0);
      cycle(1);
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("raw_rvalid", cpu_rvalid, 1);
      chk("raw_rdata", cpu_rdata, 32'h1234_5678);
      cycle(1);
      // alternating host / CPU reads
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) set_in(1, 0, 0, 0, 0, 1, 0, 10 + k, 0);
         else set_in(1, 1, 0, 20 + k, 0, 0, 0, 0, 0);
         #1;
         chk("alt_cpu_rvalid", cpu_rvalid, k > 0 && k % 2 == 0);
         chk("alt_host_rvalid", host_rvalid, k % 2 == 1);
         cycle(1);
      end
      // reset in the data cycle suppresses rvalid
      set_in(1, 1, 0, 4, 0, 0, 0, 0, 0);
      cycle(1);
      rst = 1;
      set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("rst_suppress_rvalid", cpu_rvalid, 0);
      cycle(1);
      rst = 0;
      // randomized traffic; a stalled CPU holds its request
      for (int n = 0; n < 400; n++) begin
         rst = $urandom_range(0, 63) == 0;
         enable = $urandom_range(0, 7) != 0;
         if (!last_stall) begin
            cpu_req = $urandom_range(0, 3) != 0;
            cpu_wen = $urandom_range(0, 1);
            cpu_addr = AW'($urandom_range(0, 15));
            cpu_wdata = $urandom;
         end
         host_req = $urandom_range(0, 1);
         host_wen = $urandom_range(0, 1);
         host_addr = AW'($urandom_range(0, 15));
         host_wdata = $urandom;
         cycle(1);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
